region_guard_n: RTL and testbench

- N-channel successor to the current fixed-region VRASED monitor set (AC, atomicity, DMA AC/detect).
- Each channel pairs a protected code region with a private data region. The block enforces, per channel:
  - atomic entry and exit;
  - data exclusivity;
  - no interrupts during execution;
  - no DMA access to either region.
- Any violation latches a global kill that drives the CPU reset line until the PC reaches RESET_HANDLER and a minimum hold time has elapsed.
- Violation cause and channel are captured for debug.

---
 rtl/region_guard_pkg.sv | 28 ++
 rtl/region_guard_chan.sv | 78 +++++++
 rtl/region_guard_n.sv | 128 ++++++++++++
 tb/tb_region_guard_n.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/region_guard_pkg.sv
// Shared definitions for the N-channel region guard: cause codes, FSM encodings
// and the wrap-free range compare used by every channel.
package region_guard_pkg;

  localparam logic [2:0] C_NONE   = 3'd0;
  localparam logic [2:0] C_DMA    = 3'd1;
  localparam logic [2:0] C_IRQ    = 3'd2;
  localparam logic [2:0] C_DATA   = 3'd3;
  localparam logic [2:0] C_DATA_W = 3'd4;
  localparam logic [2:0] C_ENTRY  = 3'd5;
  localparam logic [2:0] C_EXIT   = 3'd6;

  localparam logic CH_RUN  = 1'b0;
  localparam logic CH_EXEC = 1'b1;

  localparam logic G_IDLE = 1'b0;
  localparam logic G_KILL = 1'b1;

  // 17-bit compare so a region ending at 16'hFFFF never wraps; size 0 never matches.
  function automatic logic in_range(input logic [15:0] x,
                                    input logic [15:0] base,
                                    input logic [15:0] size);
    logic [16:0] w_end;
    w_end = {1'b0, base} + {1'b0, size};
    return ({1'b0, x} >= {1'b0, base}) && ({1'b0, x} < w_end);
  endfunction

endpackage

// File: rtl/region_guard_chan.sv
// One protected channel: RUN/EXEC tracking of its code region and the
// highest-priority violation it sees this cycle.
module region_guard_chan
  import region_guard_pkg::*;
#(
  parameter logic [15:0] CODE_BASE = 16'hA000,
  parameter logic [15:0] CODE_SIZE = 16'h4000,
  parameter logic [15:0] DATA_BASE = 16'h0400,
  parameter logic [15:0] DATA_SIZE = 16'h0C00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] i_pc,
  input  logic [15:0] i_prev_pc,
  input  logic        i_data_en,
  input  logic        i_data_wr,
  input  logic [15:0] i_data_addr,
  input  logic        i_dma_en,
  input  logic [15:0] i_dma_addr,
  input  logic        i_irq,
  input  logic        i_idle,
  input  logic        i_kill_entry,
  output logic [2:0]  o_cause
);

  localparam logic [15:0] EXIT_ADDR = CODE_BASE + CODE_SIZE - 16'd2;
  localparam logic        ENABLED   = (CODE_SIZE != 16'd0);

  logic r_state;
  logic w_exec;
  logic w_in_code;
  logic w_enter;
  logic w_leave;
  logic w_dma;
  logic w_irq;
  logic w_data;
  logic w_entry;
  logic w_exit;

  assign w_exec    = (r_state == CH_EXEC);
  assign w_in_code = in_range(i_pc, CODE_BASE, CODE_SIZE);
  assign w_enter   = !w_exec && w_in_code && (i_pc == CODE_BASE);
  assign w_leave   = w_exec && !w_in_code && (i_prev_pc == EXIT_ADDR);

  assign w_dma   = i_dma_en && (in_range(i_dma_addr, CODE_BASE, CODE_SIZE) ||
                                in_range(i_dma_addr, DATA_BASE, DATA_SIZE));
  assign w_irq   = i_irq && (w_exec || w_enter);
  // Data accesses are legal only from inside the channel's own code.
  assign w_data  = i_data_en && in_range(i_data_addr, DATA_BASE, DATA_SIZE) &&
                   !w_exec && !w_enter;
  assign w_entry = !w_exec && w_in_code && (i_pc != CODE_BASE);
  assign w_exit  = w_exec && !w_in_code && (i_prev_pc != EXIT_ADDR);

  always_comb begin
    o_cause = C_NONE;
    if (ENABLED) begin
      if (w_dma)                   o_cause = C_DMA;
      else if (w_irq)              o_cause = C_IRQ;
      else if (w_data && i_data_wr) o_cause = C_DATA_W;
      else if (w_data)             o_cause = C_DATA;
      else if (w_entry)            o_cause = C_ENTRY;
      else if (w_exit)             o_cause = C_EXIT;
    end
  end

  // Tracking is frozen during a kill; entering the kill drops every channel to RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= CH_RUN;
    end else if (i_kill_entry) begin
      r_state <= CH_RUN;
    end else if (i_idle) begin
      if (w_enter)      r_state <= CH_EXEC;
      else if (w_leave) r_state <= CH_RUN;
    end
  end

endmodule

// File: rtl/region_guard_n.sv
// N-channel code/data region guard: per-channel monitors, first-violation
// priority select, and the kill/hold sequencer that drives the CPU reset.
module region_guard_n
  import region_guard_pkg::*;
#(
  parameter int                   NREG          = 2,
  parameter logic [NREG*16-1:0]   CODE_BASE     = {16'hE000, 16'hA000},
  parameter logic [NREG*16-1:0]   CODE_SIZE     = {16'h0800, 16'h4000},
  parameter logic [NREG*16-1:0]   DATA_BASE     = {16'h6A00, 16'h0400},
  parameter logic [NREG*16-1:0]   DATA_SIZE     = {16'h0020, 16'h0C00},
  parameter logic [15:0]          RESET_HANDLER = 16'h0000,
  parameter int                   HOLD_CYCLES   = 4
) (
  input  logic        clk,
  input  logic        puc_rst,
  input  logic [15:0] pc,
  input  logic        data_en,
  input  logic        data_wr,
  input  logic [15:0] data_addr,
  input  logic        dma_en,
  input  logic [15:0] dma_addr,
  input  logic        irq,
  output logic        reset,
  output logic        viol_valid,
  output logic [2:0]  viol_region,
  output logic [2:0]  viol_cause
);

  localparam logic [7:0] HOLD_INIT = 8'(HOLD_CYCLES);

  logic [15:0] r_prev_pc;
  logic        r_gstate;
  logic [7:0]  r_hold;
  logic        r_reset;
  logic        r_viol_valid;
  logic [2:0]  r_viol_region;
  logic [2:0]  r_viol_cause;

  logic [2:0]  w_cause [NREG];
  logic        w_any;
  logic [2:0]  w_sel_region;
  logic [2:0]  w_sel_cause;
  logic        w_idle;
  logic        w_kill_entry;
  logic        w_release;

  assign w_idle       = (r_gstate == G_IDLE);
  assign w_kill_entry = w_idle && w_any;
  assign w_release    = (r_gstate == G_KILL) && (r_hold == 8'd0) && (pc == RESET_HANDLER);

  genvar g;
  generate
    for (g = 0; g < NREG; g++) begin : g_chan
      region_guard_chan #(
        .CODE_BASE (CODE_BASE[g*16 +: 16]),
        .CODE_SIZE (CODE_SIZE[g*16 +: 16]),
        .DATA_BASE (DATA_BASE[g*16 +: 16]),
        .DATA_SIZE (DATA_SIZE[g*16 +: 16])
      ) u_chan (
        .clk          (clk),
        .rst          (puc_rst),
        .i_pc         (pc),
        .i_prev_pc    (r_prev_pc),
        .i_data_en    (data_en),
        .i_data_wr    (data_wr),
        .i_data_addr  (data_addr),
        .i_dma_en     (dma_en),
        .i_dma_addr   (dma_addr),
        .i_irq        (irq),
        .i_idle       (w_idle),
        .i_kill_entry (w_kill_entry),
        .o_cause      (w_cause[g])
      );
    end
  endgenerate

  // Scan high-to-low so the lowest violating channel index is the one kept.
  always_comb begin
    w_any        = 1'b0;
    w_sel_region = 3'd0;
    w_sel_cause  = C_NONE;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (w_cause[i] != C_NONE) begin
        w_any        = 1'b1;
        w_sel_region = 3'(i);
        w_sel_cause  = w_cause[i];
      end
    end
  end

  always_ff @(posedge clk or posedge puc_rst) begin
    if (puc_rst) begin
      r_prev_pc     <= RESET_HANDLER;
      r_gstate      <= G_IDLE;
      r_hold        <= 8'd0;
      r_reset       <= 1'b0;
      r_viol_valid  <= 1'b0;
      r_viol_region <= 3'd0;
      r_viol_cause  <= C_NONE;
    end else begin
      r_prev_pc <= pc;
      if (r_gstate == G_IDLE) begin
        if (w_any) begin
          r_gstate      <= G_KILL;
          r_reset       <= 1'b1;
          r_hold        <= HOLD_INIT;
          r_viol_valid  <= 1'b1;
          r_viol_region <= w_sel_region;
          r_viol_cause  <= w_sel_cause;
        end
      end else begin
        // Debug capture stays frozen for the whole kill and after release.
        if (w_release) begin
          r_gstate <= G_IDLE;
          r_reset  <= 1'b0;
        end else if (r_hold != 8'd0) begin
          r_hold <= r_hold - 8'd1;
        end
      end
    end
  end

  assign reset       = r_reset;
  assign viol_valid  = r_viol_valid;
  assign viol_region = r_viol_region;
  assign viol_cause  = r_viol_cause;

endmodule

// File: tb/tb_region_guard_n.sv
// Bench for region_guard_n: default build plus a build with channel 1 disabled,
// both driven in lockstep and checked against a behavioural region model.
module tb_region_guard_n;

  logic        clk = 1'b0;
  logic        puc_rst = 1'b0;
  logic [15:0] pc = 16'h0000;
  logic        data_en = 1'b0;
  logic        data_wr = 1'b0;
  logic [15:0] data_addr = 16'h0000;
  logic        dma_en = 1'b0;
  logic [15:0] dma_addr = 16'h0000;
  logic        irq = 1'b0;

  logic        reset_a, vv_a, reset_b, vv_b;
  logic [2:0]  vr_a, vc_a, vr_b, vc_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  region_guard_n dut_a (
    .clk(clk), .puc_rst(puc_rst), .pc(pc), .data_en(data_en), .data_wr(data_wr),
    .data_addr(data_addr), .dma_en(dma_en), .dma_addr(dma_addr), .irq(irq),
    .reset(reset_a), .viol_valid(vv_a), .viol_region(vr_a), .viol_cause(vc_a)
  );

  region_guard_n #(.CODE_SIZE({16'h0000, 16'h4000})) dut_b (
    .clk(clk), .puc_rst(puc_rst), .pc(pc), .data_en(data_en), .data_wr(data_wr),
    .data_addr(data_addr), .dma_en(dma_en), .dma_addr(dma_addr), .irq(irq),
    .reset(reset_b), .viol_valid(vv_b), .viol_region(vr_b), .viol_cause(vc_b)
  );

  // Region table per instance [inst][chan]
  int cb [2]    = '{32'hA000, 32'hE000};
  int cs [2][2] = '{'{32'h4000, 32'h0800}, '{32'h4000, 32'h0000}};
  int db [2]    = '{32'h0400, 32'h6A00};
  int ds [2]    = '{32'h0C00, 32'h0020};
  localparam int HOLD = 4;
  localparam int RH   = 0;

  // Model state
  bit m_exec [2][2];
  bit m_kill [2];
  int m_hold [2];
  int m_prev [2];
  bit m_vv   [2];
  int m_vr   [2];
  int m_vc   [2];

  function automatic bit inside_rng(int x, int b, int s);
    return (x >= b) && (x < b + s);
  endfunction

  function automatic int chan_cause(int k, int ch);
    int p = int'(pc);
    bit ex = m_exec[k][ch];
    bit inc;
    bit entering;
    if (cs[k][ch] == 0) return 0;
    inc = inside_rng(p, cb[ch], cs[k][ch]);
    entering = !ex && inc && (p == cb[ch]);
    if (dma_en && (inside_rng(int'(dma_addr), cb[ch], cs[k][ch]) ||
                   inside_rng(int'(dma_addr), db[ch], ds[ch]))) return 1;
    if (irq && (ex || entering)) return 2;
    if (data_en && inside_rng(int'(data_addr), db[ch], ds[ch]) && !ex && !entering)
      return data_wr ? 4 : 3;
    if (!ex && inc && p != cb[ch]) return 5;
    if (ex && !inc && m_prev[k] != cb[ch] + cs[k][ch] - 2) return 6;
    return 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_kill[k] = 0; m_hold[k] = 0; m_prev[k] = RH;
      m_vv[k] = 0; m_vr[k] = 0; m_vc[k] = 0;
      for (int ch = 0; ch < 2; ch++) m_exec[k][ch] = 0;
    end
  endtask

  task automatic model_cycle();
    int p = int'(pc);
    for (int k = 0; k < 2; k++) begin
      if (!m_kill[k]) begin
        int first = -1;
        int cz;
        bit nxt [2];
        for (int ch = 0; ch < 2; ch++) begin
          bit inc = (cs[k][ch] != 0) && inside_rng(p, cb[ch], cs[k][ch]);
          cz = chan_cause(k, ch);
          if (cz != 0 && first < 0) begin
            first = ch; m_vc[k] = cz;
          end
          nxt[ch] = m_exec[k][ch];
          if (!m_exec[k][ch] && inc && p == cb[ch]) nxt[ch] = 1;
          if (m_exec[k][ch] && !inc && m_prev[k] == cb[ch] + cs[k][ch] - 2) nxt[ch] = 0;
        end
        if (first >= 0) begin
          m_kill[k] = 1; m_hold[k] = HOLD; m_vv[k] = 1; m_vr[k] = first;
          for (int ch = 0; ch < 2; ch++) m_exec[k][ch] = 0;
        end else begin
          for (int ch = 0; ch < 2; ch++) m_exec[k][ch] = nxt[ch];
        end
      end else begin
        if (m_hold[k] == 0 && p == RH) m_kill[k] = 0;
        else if (m_hold[k] > 0) m_hold[k]--;
      end
      m_prev[k] = p;
    end
  endtask

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(string tag);
    chk({tag, "/a.reset"}, {7'd0, reset_a}, 8'(m_kill[0]));
    chk({tag, "/a.valid"}, {7'd0, vv_a},    8'(m_vv[0]));
    chk({tag, "/a.region"}, {5'd0, vr_a},   8'(m_vr[0]));
    chk({tag, "/a.cause"}, {5'd0, vc_a},    8'(m_vc[0]));
    chk({tag, "/b.reset"}, {7'd0, reset_b}, 8'(m_kill[1]));
    chk({tag, "/b.valid"}, {7'd0, vv_b},    8'(m_vv[1]));
    chk({tag, "/b.region"}, {5'd0, vr_b},   8'(m_vr[1]));
    chk({tag, "/b.cause"}, {5'd0, vc_b},    8'(m_vc[1]));
  endtask

  task automatic step(string tag);
    model_cycle();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic quiet();
    data_en = 0; data_wr = 0; data_addr = 16'h0000;
    dma_en = 0; dma_addr = 16'h0000; irq = 0;
  endtask

  task automatic do_reset();
    quiet();
    pc = 16'h0000;
    puc_rst = 1;
    @(posedge clk);
    #1;
    model_reset();
    compare_all("reset");
    puc_rst = 0;
  endtask

  task automatic release_kill();
    quiet();
    pc = 16'h0000;
    repeat (5) step("release");
  endtask

  initial begin
    int r;
    model_reset();
    do_reset();
    chk("reset_state/reset", {7'd0, reset_a}, 8'd0);

    // Legal pass through channel 0 with private data access while executing
    pc = 16'h4400; step("legal");
    pc = 16'hA000; step("legal");
    pc = 16'hA002; data_en = 1; data_addr = 16'h0400; step("legal");
    quiet(); pc = 16'hDFFE; step("legal");
    pc = 16'h4410; step("legal");
    chk("legal/reset", {7'd0, reset_a}, 8'd0);
    chk("legal/valid", {7'd0, vv_a}, 8'd0);

    // Mid-region jump into channel 0
    pc = 16'h4400; step("jump");
    pc = 16'hA010; step("jump");
    chk("jump/reset", {7'd0, reset_a}, 8'd1);
    chk("jump/region", {5'd0, vr_a}, 8'd0);
    chk("jump/cause", {5'd0, vc_a}, 8'd5);
    pc = 16'h0000;
    repeat (4) step("jump_hold");
    chk("jump/held", {7'd0, reset_a}, 8'd1);
    step("jump_rel");
    chk("jump/released", {7'd0, reset_a}, 8'd0);
    chk("jump/kept_cause", {5'd0, vc_a}, 8'd5);

    // Write to channel 1 data outside its execution
    pc = 16'h4400; data_en = 1; data_wr = 1; data_addr = 16'h6A10; step("wr");
    chk("wr/region", {5'd0, vr_a}, 8'd1);
    chk("wr/cause", {5'd0, vc_a}, 8'd4);
    chk("wr/disabled_chan", {7'd0, reset_b}, 8'd0);
    release_kill();

    // DMA on channel 1 and IRQ in channel 0 together: channel 0 wins
    pc = 16'h4400; step("simul");
    pc = 16'hA000; step("simul");
    pc = 16'hA002; irq = 1; dma_en = 1; dma_addr = 16'hE004; step("simul");
    chk("simul/region", {5'd0, vr_a}, 8'd0);
    chk("simul/cause", {5'd0, vc_a}, 8'd2);
    release_kill();
    pc = 16'h4400; dma_en = 1; dma_addr = 16'hE004; step("dma");
    chk("dma/region", {5'd0, vr_a}, 8'd1);
    chk("dma/cause", {5'd0, vc_a}, 8'd1);

    // Second violation during the kill leaves the capture alone
    quiet(); pc = 16'h0000;
    dma_en = 1; dma_addr = 16'h0410; step("kill_ignore");
    quiet();
    repeat (4) step("kill_ignore");
    chk("kill_ignore/region", {5'd0, vr_a}, 8'd1);
    chk("kill_ignore/cause", {5'd0, vc_a}, 8'd1);
    chk("kill_ignore/released", {7'd0, reset_a}, 8'd0);

    // Asynchronous reset in the middle of a kill
    pc = 16'hA010; step("async");
    pc = 16'h0000; step("async");
    puc_rst = 1;
    #2;
    model_reset();
    compare_all("async");
    chk("async/reset", {7'd0, reset_a}, 8'd0);
    chk("async/valid", {7'd0, vv_a}, 8'd0);
    @(posedge clk); #1;
    puc_rst = 0;

    // Channel 1 disabled in instance b
    pc = 16'hE010; step("disabled");
    chk("disabled/a_cause", {5'd0, vc_a}, 8'd5);
    chk("disabled/b_reset", {7'd0, reset_b}, 8'd0);
    do_reset();
    pc = 16'hE000; step("disabled_base");
    chk("disabled_base/b_valid", {7'd0, vv_b}, 8'd0);
    do_reset();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 11);
      case (r)
        0, 1, 2, 3, 4: pc = pc + 16'd2;
        5, 6:  pc = 16'h0000;
        7:     pc = 16'h4400;
        8:     pc = 16'hA000;
        9:     pc = 16'hE000;
        10:    pc = ($urandom_range(0, 1) == 0) ? 16'hDFFE : 16'hE7FE;
        default: pc = 16'($urandom);
      endcase
      data_en = ($urandom_range(0, 4) == 0);
      data_wr = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 2))
        0: data_addr = 16'h0400 + 16'($urandom_range(0, 16'h0C10));
        1: data_addr = 16'h69F0 + 16'($urandom_range(0, 16'h40));
        default: data_addr = 16'($urandom);
      endcase
      dma_en = ($urandom_range(0, 19) == 0);
      dma_addr = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'hDFF0 + 16'($urandom_range(0, 16'h820));
      irq = ($urandom_range(0, 19) == 0);
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
